// File: rtl/cla_step_sequencer.sv
// Steps a vector counter through the CLA on each slow-clock rising edge, then settles, captures and checks.
// Optional build macro CLA_STOP_ON_ERROR_EN: a failing capture parks the FSM in HALT until reset.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a synchronized slow-clock edge while run is high
// ST_SETTLE  | operands driven, waiting for the CLA outputs to settle
// ST_CAPTURE | latch {cout_in, sum_in}, check it and pulse result_valid
// ST_HALT    | frozen on a failing vector (CLA_STOP_ON_ERROR_EN only)
module cla_step_sequencer #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             slow_clk_in,
  input  logic             run,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             cin,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic [WIDTH:0]   result_out,
  output logic             result_valid,
  output logic             error,
  output logic [15:0]      step_count,
  output logic             done
);

  localparam int VEC_BITS = 2 * WIDTH + 1;
  localparam int CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
`ifdef CLA_STOP_ON_ERROR_EN
    , ST_HALT  = 2'd3
`endif
  } state_t;

  state_t              state, state_nxt;
  logic                s1, s2, s3;
  logic                step;
  logic [VEC_BITS-1:0] vec;
  logic [CNT_W-1:0]    settle_cnt;
  logic                last_vec;
  logic [WIDTH:0]      expected;
  logic [WIDTH:0]      observed;
  logic                mismatch;
  logic                load;
  logic                settle_inc;
  logic                capture;

  // slow_clk_in is sampled as data; the history flop turns its rising edge into a one-cycle pulse
  assign step = s2 & ~s3;

  assign expected = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
  assign observed = {cout_in, sum_in};
  assign mismatch = (observed != expected);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (step && run) state_nxt = ST_SETTLE;
      ST_SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = ST_CAPTURE;
`ifdef CLA_STOP_ON_ERROR_EN
      ST_CAPTURE: state_nxt = mismatch ? ST_HALT : ST_IDLE;
      ST_HALT:    state_nxt = ST_HALT;
`else
      ST_CAPTURE: state_nxt = ST_IDLE;
`endif
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load       = 1'b0;
    settle_inc = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE:    load       = step & run;
      ST_SETTLE:  settle_inc = 1'b1;
      ST_CAPTURE: capture    = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      vec          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      cin          <= 1'b0;
      settle_cnt   <= '0;
      last_vec     <= 1'b0;
      result_out   <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      step_count   <= '0;
      done         <= 1'b0;
    end else begin
      s1           <= slow_clk_in;
      s2           <= s1;
      s3           <= s2;
      result_valid <= capture;
      if (load) begin
        op_a       <= vec[WIDTH-1:0];
        op_b       <= vec[2*WIDTH-1:WIDTH];
        cin        <= vec[2*WIDTH];
        last_vec   <= &vec;
        vec        <= vec + VEC_BITS'(1);
        settle_cnt <= '0;
      end
      if (settle_inc) begin
        settle_cnt <= settle_cnt + CNT_W'(1);
      end
      if (capture) begin
        result_out <= observed;
        if (mismatch) error <= 1'b1;
        if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
        // the vector that wrapped the counter is the last one of the full space
        if (last_vec) done <= 1'b1;
      end
    end
  end

endmodule
